// File: rtl/mini_cpu_ctrl.sv
// mini_cpu_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM sequencer driving the mini CPU datapath strobes.
// Build option MINI_CPU_MEM_TIMEOUT_EN adds a memory-wait watchdog that faults the core into HALT.
module mini_cpu_ctrl #(
  parameter int unsigned OPW         = 4,
  parameter int unsigned CNTW        = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero_flag,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic            addr_sel,
  output logic            ir_load,
  output logic            pc_inc,
  output logic            pc_load,
  output logic [1:0]      alu_op,
  output logic            reg_we,
  output logic [1:0]      wb_sel,
  output logic            halted,
  output logic            fault,
  output logic [2:0]      state,
  output logic [CNTW-1:0] retired
);

  localparam int unsigned SW = 3;

  typedef enum logic [SW-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4);
  localparam logic [OPW-1:0] OP_LDI = OPW'(5);
  localparam logic [OPW-1:0] OP_LD  = OPW'(6);
  localparam logic [OPW-1:0] OP_ST  = OPW'(7);
  localparam logic [OPW-1:0] OP_JMP = OPW'(8);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(9);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  state_t st, st_nxt;
  logic   retire_c;
  logic   fault_set_c;
  logic   timeout_c;

`ifdef MINI_CPU_MEM_TIMEOUT_EN
  // Counts consecutive cycles of an outstanding, unacknowledged request.
  logic [3:0] wcnt;

  always_ff @(posedge clk) begin
    if (reset || !(mem_req && !mem_ack)) wcnt <= '0;
    else                                 wcnt <= wcnt + 4'd1;
  end

  assign timeout_c = (wcnt == 4'(MEM_TIMEOUT));
`else
  logic [3:0] unused_timeout;
  assign unused_timeout = 4'(MEM_TIMEOUT);
  assign timeout_c      = 1'b0;
`endif

  // Datapath strobes and next state; all strobes forced low while reset is high.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    alu_op      = 2'b00;
    reg_we      = 1'b0;
    wb_sel      = 2'b00;
    retire_c    = 1'b0;
    fault_set_c = 1'b0;
    st_nxt      = st;
    if (!reset) begin
      case (st)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            st_nxt  = S_DECODE;
          end else if (timeout_c) begin
            fault_set_c = 1'b1;
            st_nxt      = S_HALT;
          end
        end
        S_DECODE: st_nxt = S_EXEC;
        S_EXEC: begin
          retire_c = 1'b1;
          st_nxt   = S_FETCH;
          case (opcode)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              alu_op = 2'(opcode - OP_ADD);
              reg_we = 1'b1;
            end
            OP_LDI: begin
              reg_we = 1'b1;
              wb_sel = 2'b01;
            end
            OP_LD, OP_ST: begin
              retire_c = 1'b0;
              st_nxt   = S_MEM;
            end
            OP_JMP: pc_load = 1'b1;
            OP_JZ:  pc_load = zero_flag;
            OP_HLT: st_nxt  = S_HALT;
            default: begin
              retire_c    = 1'b0;
              fault_set_c = 1'b1;
              st_nxt      = S_HALT;
            end
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OP_ST);
          if (mem_ack) begin
            if (opcode == OP_LD) begin
              reg_we = 1'b1;
              wb_sel = 2'b10;
            end
            retire_c = 1'b1;
            st_nxt   = S_FETCH;
          end else if (timeout_c) begin
            fault_set_c = 1'b1;
            st_nxt      = S_HALT;
          end
        end
        S_HALT:  st_nxt = S_HALT;
        default: st_nxt = S_FETCH;
      endcase
    end
  end

  // State, retire count and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= S_FETCH;
      retired <= '0;
      halted  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      st     <= st_nxt;
      halted <= (st_nxt == S_HALT);
      if (retire_c)    retired <= retired + CNTW'(1);
      if (fault_set_c) fault   <= 1'b1;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_mini_cpu_ctrl.sv
// tb_mini_cpu_ctrl: directed scenarios plus randomized opcode/ack/reset traffic checked every cycle
// against an instruction-level reference model of the sequencer.
module tb_mini_cpu_ctrl;

  localparam int unsigned OPW         = 4;
  localparam int unsigned CNTW        = 16;
  localparam int unsigned MEM_TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [OPW-1:0]  opcode;
  logic            zero_flag;
  logic            mem_ack;
  logic            mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
  logic [1:0]      alu_op;
  logic            reg_we;
  logic [1:0]      wb_sel;
  logic            halted, fault;
  logic [2:0]      state;
  logic [CNTW-1:0] retired;

  always #5 clk = ~clk;

  mini_cpu_ctrl #(.OPW(OPW), .CNTW(CNTW), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero_flag(zero_flag), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel),
    .halted(halted), .fault(fault), .state(state), .retired(retired)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase of the current instruction (spec state codes), its opcode, counters.
  int         m_ph;
  logic [3:0] m_op;
  int         m_ret;
  int         m_wait;
  logic       m_halt, m_fault;
  bit         m_known;
  logic [3:0] prog[$];
  int         zf_mode;

  // Per-scenario observations.
  int cyc, ir_mask, first_halt, mem_cnt, mwe_cnt, rwe_cnt, rwe_step, pcl_cnt;
  logic mreq_last, irl_last;

  function automatic logic [3:0] next_op();
    int r;
    if (prog.size() != 0) return prog.pop_front();
    r = int'($urandom_range(0, 99));
    if (r < 3) return 4'(10 + $urandom_range(0, 4));
    if (r < 7) return 4'd15;
    return 4'($urandom_range(0, 9));
  endfunction

  // What the outputs must be for a given instruction phase and inputs.
  function automatic logic [15:0] exp_out(input int ph, input logic [3:0] op, input logic a,
                                          input logic zf, input logic r);
    logic mreq, mwe, asel, irl, pci, pcl, rwe;
    logic [1:0] alu, wb;
    {mreq, mwe, asel, irl, pci, pcl, rwe} = '0;
    alu = 2'd0;
    wb  = 2'd0;
    if (!r) begin
      if (ph == 0) begin
        mreq = 1'b1; irl = a; pci = a;
      end else if (ph == 2) begin
        if (op >= 4'd1 && op <= 4'd4) begin alu = 2'(op - 4'd1); rwe = 1'b1; end
        else if (op == 4'd5) begin rwe = 1'b1; wb = 2'd1; end
        else if (op == 4'd8) pcl = 1'b1;
        else if (op == 4'd9) pcl = zf;
      end else if (ph == 3) begin
        mreq = 1'b1; asel = 1'b1; mwe = (op == 4'd7);
        if (a && op == 4'd6) begin rwe = 1'b1; wb = 2'd2; end
      end
    end
    return {mreq, mwe, asel, irl, pci, pcl, alu, rwe, wb, m_halt, m_fault, 3'(ph)};
  endfunction

  task automatic wait_tick();
`ifdef MINI_CPU_MEM_TIMEOUT_EN
    if (m_wait == int'(MEM_TIMEOUT)) begin
      m_fault = 1'b1; m_ph = 4; m_wait = 0;
    end else m_wait++;
`endif
  endtask

  task automatic model_update(input logic r, input logic a);
    m_known = 1'b1;
    if (r) begin
      m_ph = 0; m_ret = 0; m_wait = 0; m_halt = 1'b0; m_fault = 1'b0;
      return;
    end
    case (m_ph)
      0: if (a) begin m_op = next_op(); m_ph = 1; m_wait = 0; end else wait_tick();
      1: m_ph = 2;
      2: begin
        if (m_op == 4'd6 || m_op == 4'd7) m_ph = 3;
        else if (m_op == 4'd15) begin m_ret = (m_ret + 1) % 65536; m_ph = 4; end
        else if (m_op >= 4'd10) begin m_fault = 1'b1; m_ph = 4; end
        else begin m_ret = (m_ret + 1) % 65536; m_ph = 0; end
      end
      3: if (a) begin m_ret = (m_ret + 1) % 65536; m_ph = 0; m_wait = 0; end else wait_tick();
      default: ;
    endcase
    m_halt = (m_ph == 4);
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic mark();
    cyc = 0; ir_mask = 0; first_halt = 0; mem_cnt = 0; mwe_cnt = 0;
    rwe_cnt = 0; rwe_step = 0; pcl_cnt = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model at the edge.
  task automatic step(input logic r, input logic a);
    logic [15:0] e, act;
    cyc++;
    reset   = r;
    mem_ack = a;
    zero_flag = (zf_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(zf_mode);
    #2;
    if (m_known) begin
      e   = exp_out(m_ph, m_op, a, zero_flag, r);
      act = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, alu_op, reg_we, wb_sel,
             halted, fault, state};
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t: actual %h required %h (phase %0d op %0d ack %0b)",
                 $time, act, e, m_ph, m_op, a);
      end
      check_eq("retired", 32'(retired), 32'(m_ret));
    end
    mreq_last = mem_req;
    irl_last  = ir_load;
    if (ir_load && cyc < 32) ir_mask |= (1 << cyc);
    if (halted && first_halt == 0) first_halt = cyc;
    if (mem_req && addr_sel) mem_cnt++;
    if (mem_we) mwe_cnt++;
    if (reg_we) begin rwe_cnt++; rwe_step = cyc; end
    if (pc_load) pcl_cnt++;
    @(posedge clk);
    #1;
    model_update(r, a);
    opcode = m_op;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    opcode = '0; mem_ack = 1'b0; zero_flag = 1'b0; zf_mode = 2;
    m_ph = 0; m_op = 4'd0; m_ret = 0; m_wait = 0; m_halt = 1'b0; m_fault = 1'b0; m_known = 1'b0;
    mreq_last = 1'b0; irl_last = 1'b0;
    mark();

    // LDI, ADD, HLT with immediate ack after a 3-cycle reset.
    repeat (3) step(1'b1, 1'b1);
    mark();
    prog = '{4'd5, 4'd1, 4'd15};
    repeat (12) step(1'b0, 1'b1);
    check_eq("t1_ir_load_cycles", 32'(ir_mask), 32'h92);
    check_eq("t1_first_halted_cycle", 32'(first_halt), 32'd10);
    check_eq("t1_retired", 32'(retired), 32'd3);
    check_eq("t1_fault", 32'(fault), 32'd0);

    // LD with ack delayed two cycles in MEM.
    step(1'b1, 1'b0);
    mark();
    prog = '{4'd6};
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
    check_eq("t2_mem_cycles", 32'(mem_cnt), 32'd3);
    check_eq("t2_mem_we_cycles", 32'(mwe_cnt), 32'd0);
    check_eq("t2_reg_we_cycles", 32'(rwe_cnt), 32'd1);
    check_eq("t2_reg_we_cycle", 32'(rwe_step), 32'd6);
    check_eq("t2_state_after_6", 32'(state), 32'd0);
    check_eq("t2_retired", 32'(retired), 32'd1);

    // ST, JZ taken, JZ not taken.
    mark();
    prog = '{4'd7, 4'd9, 4'd9};
    zf_mode = 1;
    repeat (7) step(1'b0, 1'b1);
    zf_mode = 0;
    repeat (3) step(1'b0, 1'b1);
    zf_mode = 2;
    check_eq("t3_mem_we_cycles", 32'(mwe_cnt), 32'd1);
    check_eq("t3_pc_load_cycles", 32'(pcl_cnt), 32'd1);
    check_eq("t3_retired", 32'(retired), 32'd4);

    // Illegal opcode 0xB faults without retiring; reset recovers.
    step(1'b1, 1'b0);
    mark();
    prog = '{4'd11};
    repeat (4) step(1'b0, 1'b1);
    check_eq("t4_fault", 32'(fault), 32'd1);
    check_eq("t4_halted", 32'(halted), 32'd1);
    check_eq("t4_retired", 32'(retired), 32'd0);
    step(1'b1, 1'b0);
    check_eq("t4_fault_after_reset", 32'(fault), 32'd0);
    check_eq("t4_state_after_reset", 32'(state), 32'd0);

    // Reset during a FETCH wait; the late ack must be ignored.
    mark();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("t5_mem_req_waiting", 32'(mreq_last), 32'd1);
    step(1'b1, 1'b0);
    check_eq("t5_mem_req_in_reset", 32'(mreq_last), 32'd0);
    step(1'b1, 1'b1);
    check_eq("t5_ir_load_late_ack", 32'(irl_last), 32'd0);
    step(1'b0, 1'b0);
    check_eq("t5_retired", 32'(retired), 32'd0);

    // Memory never acknowledges.
    mark();
    repeat (100) step(1'b0, 1'b0);
`ifdef MINI_CPU_MEM_TIMEOUT_EN
    check_eq("t6_fault", 32'(fault), 32'd1);
    check_eq("t6_halted", 32'(halted), 32'd1);
    check_eq("t6_mem_req", 32'(mem_req), 32'd0);
`else
    check_eq("t6_state_fetch", 32'(state), 32'd0);
    check_eq("t6_fault", 32'(fault), 32'd0);
    check_eq("t6_mem_req", 32'(mem_req), 32'd1);
`endif

    // Randomized traffic; reset occasionally, and often once halted.
    step(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic a, r;
      a = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 199) == 0) || (m_halt && $urandom_range(0, 7) == 0);
      step(r, a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
